// File: rtl/jelly2_texture_cache_fill_pkg.sv
// Shared types for the texture cache fill/issue sequencer.
package jelly2_texture_cache_pkg;

  // Field widths of the latched miss request; the sequencer's parameters default to these.
  localparam int PKG_USER_WIDTH      = 1;
  localparam int PKG_TBL_ADDR_WIDTH  = 6;
  localparam int PKG_PIX_ADDR_WIDTH  = 4;
  localparam int PKG_LINE_ADDR_WIDTH = 24;

  typedef enum logic [1:0] {
    PASS = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    READ = 2'd3
  } state_t;

  // The original lookup request, held while its line is being fetched.
  typedef struct packed {
    logic [PKG_USER_WIDTH-1:0]      user;
    logic                           last;
    logic                           strb;
    logic [PKG_TBL_ADDR_WIDTH-1:0]  tbl_addr;
    logic [PKG_PIX_ADDR_WIDTH-1:0]  pix_addr;
    logic [PKG_LINE_ADDR_WIDTH-1:0] line_addr;
  } req_t;

endpackage

// File: rtl/jelly2_texture_cache_fill_if.sv
// Cache memory access bus: read or write-word commands with valid/ready.
interface jelly2_texture_cache_fill_if #(
  parameter int USER_WIDTH     = jelly2_texture_cache_pkg::PKG_USER_WIDTH,
  parameter int COMPONENT_NUM  = 1,
  parameter int WORD_WIDTH     = 48,
  parameter int TBL_ADDR_WIDTH = jelly2_texture_cache_pkg::PKG_TBL_ADDR_WIDTH,
  parameter int PIX_ADDR_WIDTH = jelly2_texture_cache_pkg::PKG_PIX_ADDR_WIDTH
);
  logic [USER_WIDTH-1:0]     user;
  logic                      last;
  logic                      strb;
  logic [COMPONENT_NUM-1:0]  we;
  logic [WORD_WIDTH-1:0]     wdata;
  logic [TBL_ADDR_WIDTH-1:0] tbl_addr;
  logic [PIX_ADDR_WIDTH-1:0] pix_addr;
  logic                      valid;
  logic                      ready;

  modport master (output user, last, strb, we, wdata, tbl_addr, pix_addr, valid, input ready);
  modport slave  (input user, last, strb, we, wdata, tbl_addr, pix_addr, valid, output ready);
endinterface

// File: rtl/jelly2_texture_cache_fill_out_reg.sv
// Single-entry valid/ready output register driving the cache memory bus.
module jelly2_texture_cache_out_reg
  import jelly2_texture_cache_pkg::*;
#(
  parameter int USER_WIDTH     = PKG_USER_WIDTH,
  parameter int COMPONENT_NUM  = 1,
  parameter int WORD_WIDTH     = 48,
  parameter int TBL_ADDR_WIDTH = PKG_TBL_ADDR_WIDTH,
  parameter int PIX_ADDR_WIDTH = PKG_PIX_ADDR_WIDTH
) (
  input  logic                      reset_n,
  input  logic                      clk,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [USER_WIDTH-1:0]     in_user,
  input  logic                      in_last,
  input  logic                      in_strb,
  input  logic [COMPONENT_NUM-1:0]  in_we,
  input  logic [WORD_WIDTH-1:0]     in_wdata,
  input  logic [TBL_ADDR_WIDTH-1:0] in_tbl_addr,
  input  logic [PIX_ADDR_WIDTH-1:0] in_pix_addr,
  jelly2_texture_cache_fill_if.master m
);

  // The slot is free when empty or being drained this cycle.
  assign in_ready = !m.valid || m.ready;

  // Valid flag: load new entry, or drop the drained one when nothing arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m.valid <= 1'b0;
    end else if (in_ready) begin
      m.valid <= in_valid;
    end
  end

  // Payload carries no reset; it is only meaningful while valid is set.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      m.user     <= in_user;
      m.last     <= in_last;
      m.strb     <= in_strb;
      m.we       <= in_we;
      m.wdata    <= in_wdata;
      m.tbl_addr <= in_tbl_addr;
      m.pix_addr <= in_pix_addr;
    end
  end

endmodule

// File: rtl/jelly2_texture_cache_fill.sv
// Fill/issue sequencer in front of the texture cache memory: hits pass
// straight through as reads, misses fetch the line, write it into the slot,
// then replay the original read so downstream always sees the fresh line.
module jelly2_texture_cache_fill
  import jelly2_texture_cache_pkg::*;
#(
  parameter int USER_WIDTH           = PKG_USER_WIDTH,
  parameter int COMPONENT_NUM        = 1,
  parameter int COMPONENT_DATA_WIDTH = 24,
  parameter int TBL_ADDR_WIDTH       = PKG_TBL_ADDR_WIDTH,
  parameter int PIX_ADDR_WIDTH       = PKG_PIX_ADDR_WIDTH,
  parameter int S_DATA_SIZE          = 1,
  parameter int LINE_ADDR_WIDTH      = PKG_LINE_ADDR_WIDTH,
  localparam int WORD_WIDTH          = (COMPONENT_NUM * COMPONENT_DATA_WIDTH) << S_DATA_SIZE,
  localparam int BEAT_NUM            = 1 << (PIX_ADDR_WIDTH - S_DATA_SIZE)
) (
  input  logic                       reset_n,
  input  logic                       clk,
  output logic                       busy,
  output logic                       fill_error,

  input  logic [USER_WIDTH-1:0]      s_user,
  input  logic                       s_last,
  input  logic                       s_strb,
  input  logic                       s_hit,
  input  logic [LINE_ADDR_WIDTH-1:0] s_line_addr,
  input  logic [TBL_ADDR_WIDTH-1:0]  s_tbl_addr,
  input  logic [PIX_ADDR_WIDTH-1:0]  s_pix_addr,
  input  logic                       s_valid,
  output logic                       s_ready,

  output logic [LINE_ADDR_WIDTH-1:0] m_req_addr,
  output logic                       m_req_valid,
  input  logic                       m_req_ready,

  input  logic [WORD_WIDTH-1:0]      s_fill_data,
  input  logic                       s_fill_last,
  input  logic                       s_fill_valid,
  output logic                       s_fill_ready,

  jelly2_texture_cache_fill_if.master m
);

  localparam int BEAT_CNT_WIDTH = (PIX_ADDR_WIDTH > S_DATA_SIZE) ? (PIX_ADDR_WIDTH - S_DATA_SIZE) : 1;
  localparam logic [BEAT_CNT_WIDTH-1:0] BEAT_LAST = BEAT_CNT_WIDTH'(BEAT_NUM - 1);

  state_t                    state_reg, state_next;
  logic [BEAT_CNT_WIDTH-1:0] beat_reg, beat_next;
  logic                      fill_error_reg, fill_error_next;
  req_t                      req_reg, req_next;

  logic                      ld_valid;
  logic                      ld_ready;
  logic [USER_WIDTH-1:0]     ld_user;
  logic                      ld_last;
  logic                      ld_strb;
  logic [COMPONENT_NUM-1:0]  ld_we;
  logic [WORD_WIDTH-1:0]     ld_wdata;
  logic [TBL_ADDR_WIDTH-1:0] ld_tbl_addr;
  logic [PIX_ADDR_WIDTH-1:0] ld_pix_addr;

  // Control state: sequencer state, beat counter and sticky fill error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= PASS;
      beat_reg       <= '0;
      fill_error_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      beat_reg       <= beat_next;
      fill_error_reg <= fill_error_next;
    end
  end

  // Latched miss request; data only, so it needs no reset.
  always_ff @(posedge clk) begin
    req_reg <= req_next;
  end

  // Next state, handshakes and the command offered to the output register.
  always_comb begin
    state_next      = state_reg;
    beat_next       = beat_reg;
    fill_error_next = fill_error_reg;
    req_next        = req_reg;
    s_ready         = 1'b0;
    s_fill_ready    = 1'b0;
    m_req_valid     = 1'b0;
    ld_valid        = 1'b0;
    ld_user         = req_reg.user;
    ld_last         = req_reg.last;
    ld_strb         = req_reg.strb;
    ld_we           = '0;
    ld_wdata        = '0;
    ld_tbl_addr     = req_reg.tbl_addr;
    ld_pix_addr     = req_reg.pix_addr;

    case (state_reg)
      PASS: begin
        s_ready = ld_ready;
        if (s_valid && ld_ready) begin
          if (s_hit || !s_strb) begin
            // Hits and blank pixels go straight out as reads.
            ld_valid    = 1'b1;
            ld_user     = s_user;
            ld_last     = s_last;
            ld_strb     = s_strb;
            ld_tbl_addr = s_tbl_addr;
            ld_pix_addr = s_pix_addr;
          end else begin
            req_next.user      = s_user;
            req_next.last      = s_last;
            req_next.strb      = s_strb;
            req_next.tbl_addr  = s_tbl_addr;
            req_next.pix_addr  = s_pix_addr;
            req_next.line_addr = s_line_addr;
            state_next         = REQ;
          end
        end
      end

      REQ: begin
        m_req_valid = 1'b1;
        if (m_req_ready) begin
          state_next = FILL;
        end
      end

      FILL: begin
        s_fill_ready = ld_ready;
        if (s_fill_valid && ld_ready) begin
          ld_valid    = 1'b1;
          ld_we       = '1;
          ld_wdata    = s_fill_data;
          ld_strb     = 1'b1;
          ld_last     = 1'b0;
          ld_pix_addr = PIX_ADDR_WIDTH'(beat_reg) << S_DATA_SIZE;
          // The counter ends the fill; fill_last is only cross-checked.
          if (beat_reg == BEAT_LAST) begin
            beat_next  = '0;
            state_next = READ;
            if (!s_fill_last) begin
              fill_error_next = 1'b1;
            end
          end else begin
            beat_next = beat_reg + BEAT_CNT_WIDTH'(1);
            if (s_fill_last) begin
              fill_error_next = 1'b1;
            end
          end
        end
      end

      READ: begin
        // Replay the original read now that the slot holds the fresh line.
        ld_valid = 1'b1;
        if (ld_ready) begin
          state_next = PASS;
        end
      end

      default: state_next = PASS;
    endcase
  end

  assign m_req_addr = req_reg.line_addr;
  assign fill_error = fill_error_reg;
  assign busy       = (state_reg != PASS) || m.valid;

  jelly2_texture_cache_out_reg #(
    .USER_WIDTH     (USER_WIDTH),
    .COMPONENT_NUM  (COMPONENT_NUM),
    .WORD_WIDTH     (WORD_WIDTH),
    .TBL_ADDR_WIDTH (TBL_ADDR_WIDTH),
    .PIX_ADDR_WIDTH (PIX_ADDR_WIDTH)
  ) u_out_reg (
    .reset_n     (reset_n),
    .clk         (clk),
    .in_valid    (ld_valid),
    .in_ready    (ld_ready),
    .in_user     (ld_user),
    .in_last     (ld_last),
    .in_strb     (ld_strb),
    .in_we       (ld_we),
    .in_wdata    (ld_wdata),
    .in_tbl_addr (ld_tbl_addr),
    .in_pix_addr (ld_pix_addr),
    .m           (m)
  );

endmodule

// File: tb/tb_jelly2_texture_cache_fill.sv
// Directed bench for the texture cache fill sequencer.
module tb_jelly2_texture_cache_fill;

  localparam int BEAT_NUM = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        busy, fill_error;
  logic        s_user, s_last, s_strb, s_hit, s_valid, s_ready;
  logic [23:0] s_line_addr;
  logic [5:0]  s_tbl_addr;
  logic [3:0]  s_pix_addr;
  logic [23:0] m_req_addr;
  logic        m_req_valid, m_req_ready;
  logic [47:0] s_fill_data;
  logic        s_fill_last, s_fill_valid, s_fill_ready;

  always #5 clk = ~clk;

  jelly2_texture_cache_fill_if #(
    .USER_WIDTH(1), .COMPONENT_NUM(1), .WORD_WIDTH(48), .TBL_ADDR_WIDTH(6), .PIX_ADDR_WIDTH(4)
  ) m_if ();

  jelly2_texture_cache_fill #(
    .USER_WIDTH(1), .COMPONENT_NUM(1), .COMPONENT_DATA_WIDTH(24), .TBL_ADDR_WIDTH(6),
    .PIX_ADDR_WIDTH(4), .S_DATA_SIZE(1), .LINE_ADDR_WIDTH(24)
  ) dut (
    .reset_n(reset_n), .clk(clk), .busy(busy), .fill_error(fill_error),
    .s_user(s_user), .s_last(s_last), .s_strb(s_strb), .s_hit(s_hit),
    .s_line_addr(s_line_addr), .s_tbl_addr(s_tbl_addr), .s_pix_addr(s_pix_addr),
    .s_valid(s_valid), .s_ready(s_ready),
    .m_req_addr(m_req_addr), .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .s_fill_data(s_fill_data), .s_fill_last(s_fill_last),
    .s_fill_valid(s_fill_valid), .s_fill_ready(s_fill_ready),
    .m(m_if)
  );

  typedef struct {
    logic        we;
    logic [47:0] wdata;
    logic [5:0]  tbl;
    logic [3:0]  pix;
    logic        strb;
    logic        last;
    logic        user;
    int          cyc;
  } tx_t;

  tx_t q[$];
  int  cyc = 0;
  int  req_cycles = 0;
  int  n_checks = 0;
  int  n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every downstream handshake; valid/ready are stable until the next rising edge.
  always @(negedge clk) begin : mon
    tx_t t;
    if (reset_n && m_if.valid && m_if.ready) begin
      t.we = m_if.we; t.wdata = m_if.wdata; t.tbl = m_if.tbl_addr; t.pix = m_if.pix_addr;
      t.strb = m_if.strb; t.last = m_if.last; t.user = m_if.user; t.cyc = cyc;
      q.push_back(t);
      $display("tx cyc=%0d we=%0b tbl=%0d pix=%0d strb=%0b last=%0b wdata=%h",
               cyc, t.we, t.tbl, t.pix, t.strb, t.last, t.wdata);
    end
    if (reset_n && m_req_valid) req_cycles++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] fill_word(input int k);
    return {8'hF0, 8'(k), 32'hDEAD_0000 + 32'(k)};
  endfunction

  task automatic check_tx(input string tag, input int idx, input logic we, input logic [47:0] wd,
                          input logic [5:0] tbl, input logic [3:0] pix, input logic strb,
                          input logic last, input logic user);
    if (idx >= q.size()) begin
      check($sformatf("%s%0d_missing", tag, idx), 64'(q.size()), 64'(idx + 1));
      return;
    end
    check($sformatf("%s%0d_we", tag, idx),   q[idx].we,   we);
    check($sformatf("%s%0d_tbl", tag, idx),  q[idx].tbl,  tbl);
    check($sformatf("%s%0d_pix", tag, idx),  q[idx].pix,  pix);
    check($sformatf("%s%0d_strb", tag, idx), q[idx].strb, strb);
    check($sformatf("%s%0d_last", tag, idx), q[idx].last, last);
    if (we) check($sformatf("%s%0d_wdata", tag, idx), q[idx].wdata, wd);
    else    check($sformatf("%s%0d_user", tag, idx), q[idx].user, user);
  endtask

  task automatic send_req(input logic user, input logic last, input logic strb, input logic hit,
                          input logic [23:0] line, input logic [5:0] tbl, input logic [3:0] pix);
    logic acc;
    s_user = user; s_last = last; s_strb = strb; s_hit = hit;
    s_line_addr = line; s_tbl_addr = tbl; s_pix_addr = pix; s_valid = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 40 && !acc; t++) begin
      @(negedge clk); acc = s_ready;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    check("req_accept", acc, 1'b1);
  endtask

  task automatic wait_out(input int n);
    for (int t = 0; t < 60; t++) begin
      if (q.size() >= n) break;
      @(posedge clk); #1;
    end
    check("out_count", 64'(q.size()), 64'(n));
  endtask

  // Answer the line fetch, then stream nbeats fill words; with toggle, m_ready flips every cycle.
  task automatic run_fill(input int nbeats, input int bad_beat, input bit toggle,
                          input logic [23:0] exp_line, output int sready_hi);
    logic seen, acc;
    int   r0;
    sready_hi = 0;
    r0 = req_cycles;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk); seen = m_req_valid;
    end
    check("req_valid_seen", seen, 1'b1);
    check("req_addr", m_req_addr, exp_line);
    m_req_ready = 1'b1;
    @(posedge clk); #1;
    m_req_ready = 1'b0;
    @(negedge clk);
    check("req_valid_drop", m_req_valid, 1'b0);
    check("req_once", 64'(req_cycles - r0), 64'd1);
    @(posedge clk); #1;
    for (int k = 0; k < nbeats; k++) begin
      s_fill_data  = fill_word(k);
      s_fill_last  = (bad_beat >= 0) ? (k == bad_beat) : (k == BEAT_NUM - 1);
      s_fill_valid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 40 && !acc; t++) begin
        @(negedge clk);
        if (s_ready) sready_hi++;
        acc = s_fill_ready;
        @(posedge clk); #1;
        if (toggle) m_if.ready = ~m_if.ready;
      end
      if (!acc) check($sformatf("fill_beat%0d_accept", k), acc, 1'b1);
    end
    s_fill_valid = 1'b0;
    s_fill_last  = 1'b0;
    if (nbeats == BEAT_NUM) begin
      for (int t = 0; t < 40; t++) begin
        if (q.size() >= BEAT_NUM + 1) break;
        @(posedge clk); #1;
        if (toggle) m_if.ready = ~m_if.ready;
      end
      m_if.ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("miss_tx_count", 64'(q.size()), 64'(BEAT_NUM + 1));
    end
  endtask

  task automatic check_miss(input string tag, input logic [5:0] tbl, input logic [3:0] pix,
                            input logic last, input logic user);
    for (int k = 0; k < BEAT_NUM; k++)
      check_tx(tag, k, 1'b1, fill_word(k), tbl, 4'(k * 2), 1'b1, 1'b0, user);
    check_tx(tag, BEAT_NUM, 1'b0, 48'h0, tbl, pix, 1'b1, last, user);
  endtask

  initial begin : stim
    int k0, sr, r0;
    s_user = 0; s_last = 0; s_strb = 0; s_hit = 0; s_valid = 0;
    s_line_addr = '0; s_tbl_addr = '0; s_pix_addr = '0;
    m_req_ready = 0; s_fill_data = '0; s_fill_last = 0; s_fill_valid = 0;
    m_if.ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", m_if.valid, 1'b0);
    check("rst_req_valid", m_req_valid, 1'b0);
    check("rst_fill_error", fill_error, 1'b0);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_fill_ready", s_fill_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset_n = 1'b1;

    // Hit stream: four back-to-back hits, one read per cycle, latency 1
    @(posedge clk); #1;
    k0 = cyc;
    for (int i = 0; i < 4; i++) begin
      s_user = 1'b0; s_last = (i == 3); s_strb = 1'b1; s_hit = 1'b1;
      s_line_addr = 24'h0; s_tbl_addr = 6'd3; s_pix_addr = 4'(i); s_valid = 1'b1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    @(negedge clk);
    check("hit_busy_last", busy, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("hit_busy_drop", busy, 1'b0);
    check("hit_count", 64'(q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check_tx("hit", i, 1'b0, 48'h0, 6'd3, 4'(i), 1'b1, (i == 3), 1'b0);
      if (i < q.size()) check($sformatf("hit%0d_cycle", i), 64'(q[i].cyc), 64'(k0 + 1 + i));
    end

    // Miss: slot 5, pix 9, line 0x123
    q.delete();
    @(posedge clk); #1;
    send_req(1'b1, 1'b1, 1'b1, 1'b0, 24'h123, 6'd5, 4'd9);
    run_fill(BEAT_NUM, -1, 1'b0, 24'h123, sr);
    check_miss("miss", 6'd5, 4'd9, 1'b1, 1'b1);
    check("miss_s_ready_low", 64'(sr), 64'd0);
    check("miss_fill_error", fill_error, 1'b0);
    check("miss_busy_done", busy, 1'b0);

    // Miss with downstream backpressure toggling
    q.delete();
    send_req(1'b0, 1'b0, 1'b1, 1'b0, 24'h3C5A1, 6'd12, 4'd6);
    run_fill(BEAT_NUM, -1, 1'b1, 24'h3C5A1, sr);
    check_miss("bp", 6'd12, 4'd6, 1'b0, 1'b0);
    check("bp_s_ready_low", 64'(sr), 64'd0);
    check("bp_fill_error", fill_error, 1'b0);

    // Blank pixel: strb=0, hit=0 is a plain read, no fetch
    q.delete();
    r0 = req_cycles;
    send_req(1'b1, 1'b1, 1'b0, 1'b0, 24'h456, 6'd7, 4'd3);
    wait_out(1);
    check_tx("blank", 0, 1'b0, 48'h0, 6'd7, 4'd3, 1'b0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("blank_no_req", 64'(req_cycles - r0), 64'd0);

    // Bad fill_last on beat 5: error latches, sequence unchanged
    q.delete();
    send_req(1'b0, 1'b0, 1'b1, 1'b0, 24'hABCDE, 6'd9, 4'd4);
    run_fill(BEAT_NUM, 5, 1'b0, 24'hABCDE, sr);
    check_miss("bad", 6'd9, 4'd4, 1'b0, 1'b0);
    check("bad_fill_error", fill_error, 1'b1);
    q.delete();
    send_req(1'b0, 1'b1, 1'b1, 1'b1, 24'h0, 6'd1, 4'd2);
    wait_out(1);
    check_tx("after_bad", 0, 1'b0, 48'h0, 6'd1, 4'd2, 1'b1, 1'b1, 1'b0);
    check("bad_error_sticky", fill_error, 1'b1);

    // Reset in the middle of a fill, after beat 3
    q.delete();
    send_req(1'b0, 1'b0, 1'b1, 1'b0, 24'h777, 6'd20, 4'd1);
    run_fill(4, -1, 1'b0, 24'h777, sr);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_m_valid", m_if.valid, 1'b0);
    check("mid_rst_req_valid", m_req_valid, 1'b0);
    check("mid_rst_s_ready", s_ready, 1'b1);
    check("mid_rst_fill_ready", s_fill_ready, 1'b0);
    check("mid_rst_fill_error", fill_error, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    q.delete();
    @(posedge clk); #1;
    send_req(1'b1, 1'b0, 1'b1, 1'b1, 24'h0, 6'd33, 4'd15);
    wait_out(1);
    check_tx("post_rst", 0, 1'b0, 48'h0, 6'd33, 4'd15, 1'b1, 1'b0, 1'b1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jelly2_texture_cache_fill.md
Name: jelly2_texture_cache_fill

Overview:
- Fill/issue sequencer directly upstream of the texture cache memory stage.
- Takes tag-lookup results as (table slot, pixel address, hit flag, line address).
- Hits are forwarded as plain reads.
- Misses trigger this sequence:
  - issue one external line-fetch request;
  - write the returned beats into the cache slot as write-words;
  - then issue the original read, so downstream always sees the fresh line.

Parameters:
- USER_WIDTH, 1, sideband carried with each request
- COMPONENT_NUM, 1, colour components (one write-enable bit each)
- COMPONENT_DATA_WIDTH, 24, bits per component per pixel
- TBL_ADDR_WIDTH, 6, cache slot index width
- PIX_ADDR_WIDTH, 4, pixel index within a line
- S_DATA_SIZE, 1, log2 pixels per memory word
- LINE_ADDR_WIDTH, 24, external line address width
- Local constant WORD_WIDTH = (COMPONENT_NUM*COMPONENT_DATA_WIDTH)<<S_DATA_SIZE.
- Local constant BEAT_NUM = 1<<(PIX_ADDR_WIDTH-S_DATA_SIZE).

Ports:
- reset_n  in  1  asynchronous active-low reset
- clk  in  1  clock
- busy  out  1  any state other than PASS, or m_valid set
- fill_error  out  1  sticky: fill_last disagreed with beat count
- s_user  in  USER_WIDTH  request sideband
- s_last  in  1  last-of-group marker
- s_strb  in  1  0 = out-of-range pixel (blank); forced to hit path
- s_hit  in  1  tag hit
- s_line_addr  in  LINE_ADDR_WIDTH  external line address (used on miss)
- s_tbl_addr  in  TBL_ADDR_WIDTH  cache slot
- s_pix_addr  in  PIX_ADDR_WIDTH  pixel index
- s_valid / s_ready  in / out  1  request handshake
- m_req_addr  out  LINE_ADDR_WIDTH  line fetch address
- m_req_valid / m_req_ready  out / in  1  fetch handshake
- s_fill_data  in  WORD_WIDTH  returned line word
- s_fill_last  in  1  final beat flag
- s_fill_valid / s_fill_ready  in / out  1  fill handshake
- m_user, m_last, m_strb  out  USER_WIDTH, 1, 1  to cache memory
- m_we  out  COMPONENT_NUM  all-ones on fill writes, 0 on reads
- m_wdata  out  WORD_WIDTH  fill word
- m_tbl_addr, m_pix_addr  out  TBL_ADDR_WIDTH, PIX_ADDR_WIDTH
- m_valid / m_ready  out / in  1  downstream handshake

Behaviour:
- Reset (async assert, sync deassert expected upstream):
  - state=PASS; m_valid=0, m_req_valid=0, fill_error=0, beat counter=0;
  - s_ready=1 and s_fill_ready=0 combinationally after reset;
  - other m_* data registers are don't-care.
- Output register: single-entry. It loads when (!m_valid || m_ready); m_valid clears on m_ready with no new load.
- States:
  - PASS: s_ready = output register can load.
    - Accept with (s_hit || !s_strb): next cycle m_valid=1, m_we=0, fields copied. Hit latency is 1 cycle; one request per cycle is sustained.
    - Accept with s_strb && !s_hit: latch the request, go to REQ; nothing is emitted.
  - REQ: m_req_valid=1, m_req_addr=latched line address. On m_req_ready go to FILL. m_req_valid drops the cycle after the handshake.
  - FILL: s_fill_ready = output register can load.
    - Each accepted beat k (0..BEAT_NUM-1) emits next cycle: m_we=all-ones, m_wdata=beat, m_tbl_addr=latched slot, m_pix_addr=k<<S_DATA_SIZE, m_strb=1, m_last=0.
    - The counter increments and wraps to 0 after BEAT_NUM-1.
    - After beat BEAT_NUM-1, go to READ.
  - READ: load the latched original request with m_we=0, then return to PASS. s_ready=0 during this cycle.
- Fill termination is counter-driven. If s_fill_last=1 on a beat other than BEAT_NUM-1, or s_fill_last=0 on beat BEAT_NUM-1, set fill_error (sticky until reset) and still follow the counter.
- s_ready=0 in REQ/FILL/READ; s_fill_ready=0 outside FILL.
- Beat and handshake rules:
  - A fill beat presented outside FILL is never accepted.
  - m_ready low stalls FILL/READ without losing a beat.
  - m_req_ready high before REQ is ignored.
- Reset mid-fill aborts the fill. The slot contents are then undefined; the tag stage is reset together with this block.

Decomposition:
- Package jelly2_texture_cache_pkg:
  - state enum {PASS, REQ, FILL, READ};
  - request struct {user, last, strb, tbl_addr, pix_addr, line_addr}.
- Output register is a natural sub-module: jelly2_texture_cache_out_reg (valid/ready single-entry register, async active-low reset).

Test Plan (PIX_ADDR_WIDTH=4, S_DATA_SIZE=1, BEAT_NUM=8):
- Hit stream: 4 back-to-back hits slots 3, pix 0..3 with m_ready=1 -> 4 reads on consecutive cycles, 1-cycle latency, m_we=0, busy drops after last.
- Miss: slot 5, pix 9, line 0x123 -> m_req_addr=0x123 once; 8 fill beats emit writes at pix 0,2,..,14 slot 5; then one read pix 9, we=0; fill_error=0.
- Fill backpressure: m_ready toggled 1/0 during the miss -> all 8 writes and the read are emitted in order, none dropped or duplicated, s_ready=0 throughout.
- Bad last: s_fill_last on beat 5 -> fill_error=1, still 8 writes and 1 read; fill_error holds until reset.
- Blank: s_strb=0, s_hit=0 -> passes through as a read with m_strb=0, and no m_req_valid.
- Reset mid-FILL after beat 3 -> m_valid=0, m_req_valid=0, s_ready=1, s_fill_ready=0; next hit request proceeds normally.
